// File: rtl/lrc8_accumulator_pkg.sv
// -----------------------------------------------------------------------------
// lrc8_accumulator_pkg
// Shared definitions for the byte-serial LRC accumulator:
//   - FSM state encoding (IDLE/ACCUM/DRAIN/HOLD)
//   - default frame length limit and byte counter width
// No ports; imported by the accumulator top.
// -----------------------------------------------------------------------------
package lrc8_accumulator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,  // no bytes folded yet in this frame
    ST_ACCUM = 2'b01,  // folding bytes into the accumulator
    ST_DRAIN = 2'b10,  // frame overlength: swallow bytes until IN_LAST
    ST_HOLD  = 2'b11   // result presented, waiting for downstream
  } lrc_state_e;

  localparam int LRC_MAX_LEN_DEF = 16;
  localparam int LRC_CNT_W_DEF   = 5;

endpackage

// File: rtl/lrc8_accumulator_xor8.sv
// -----------------------------------------------------------------------------
// lrc8_accumulator_xor8
// 8-bit bitwise XOR gate used as the accumulate datapath.
// Ports:
//   a [7:0] in  - first operand (running accumulator)
//   b [7:0] in  - second operand (incoming byte)
//   y [7:0] out - a ^ b
// -----------------------------------------------------------------------------
module lrc8_accumulator_xor8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] y
);

  assign y = a ^ b;

endmodule

// File: rtl/lrc8_accumulator.sv
// -----------------------------------------------------------------------------
// lrc8_accumulator
// Byte-serial longitudinal redundancy check (running XOR) engine. Bytes arrive
// over a valid/ready handshake and are folded into an 8-bit accumulator; the
// frame checksum, byte count and overlength flag are presented on a
// valid/ready result port.
// Ports:
//   clk        in            rising-edge clock
//   rst_n      in            asynchronous active-low reset
//   in_valid   in            upstream byte valid
//   in_ready   out           block can accept a byte (low only in HOLD)
//   in_data    in  [7:0]     frame byte
//   in_last    in            final byte of the frame (qualified by in_valid)
//   out_valid  out           result valid
//   out_ready  in            downstream accepts the result
//   out_lrc    out [7:0]     XOR of all in-frame bytes that were folded
//   out_len    out [CNT_W]   number of bytes folded into out_lrc
//   out_err    out           frame exceeded MAX_LEN
// -----------------------------------------------------------------------------
module lrc8_accumulator
  import lrc8_accumulator_pkg::*;
#(
  parameter int MAX_LEN = LRC_MAX_LEN_DEF,
  parameter int CNT_W   = LRC_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_lrc,
  output logic [CNT_W-1:0] out_len,
  output logic             out_err
);

  lrc_state_e       state_r;
  logic [7:0]       acc_r;
  logic [CNT_W-1:0] cnt_r;
  logic [7:0]       acc_next_s;
  logic [CNT_W-1:0] cnt_next_s;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [7:0]       out_lrc_r;
  logic [CNT_W-1:0] out_len_r;
  logic             out_err_r;

  // Accumulate datapath: fold the incoming byte into the running XOR.
  lrc8_accumulator_xor8 u_xor8 (
    .a (acc_r),
    .b (in_data),
    .y (acc_next_s)
  );

  assign cnt_next_s = cnt_r + CNT_W'(1);

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_lrc   = out_lrc_r;
  assign out_len   = out_len_r;
  assign out_err   = out_err_r;

  // Frame FSM with accumulator, byte counter and registered result port.
  // in_ready_r is kept as a register that mirrors "state != HOLD" so the
  // handshake output never comes from a decode of the state vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      acc_r       <= 8'h00;
      cnt_r       <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_lrc_r   <= 8'h00;
      out_len_r   <= '0;
      out_err_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_ACCUM: begin
          // in_ready is high here, so in_valid alone marks a transfer
          if (in_valid) begin
            acc_r <= acc_next_s;
            cnt_r <= cnt_next_s;
            // IN_LAST wins over the length limit: a MAX_LEN-th byte that is
            // also last closes the frame cleanly without an error
            if (in_last) begin
              state_r     <= ST_HOLD;
              in_ready_r  <= 1'b0;
              out_valid_r <= 1'b1;
              out_lrc_r   <= acc_next_s;
              out_len_r   <= cnt_next_s;
              out_err_r   <= 1'b0;
            end else if (cnt_next_s == CNT_W'(MAX_LEN)) begin
              state_r <= ST_DRAIN;
            end else begin
              state_r <= ST_ACCUM;
            end
          end else begin
            state_r <= state_r;
          end
        end
        ST_DRAIN: begin
          // accumulator and counter stay frozen; bytes are swallowed
          if (in_valid && in_last) begin
            state_r     <= ST_HOLD;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b1;
            out_lrc_r   <= acc_r;
            out_len_r   <= cnt_r;
            out_err_r   <= 1'b1;
          end else begin
            state_r <= ST_DRAIN;
          end
        end
        ST_HOLD: begin
          // result registers keep their values until the next HOLD entry
          if (out_ready) begin
            state_r     <= ST_IDLE;
            acc_r       <= 8'h00;
            cnt_r       <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
          end else begin
            state_r <= ST_HOLD;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          acc_r       <= 8'h00;
          cnt_r       <= '0;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lrc8_accumulator.sv
// -----------------------------------------------------------------------------
// tb_lrc8_accumulator
// Directed-vector bench for lrc8_accumulator with hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_lrc8_accumulator;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_lrc;
  logic [4:0] out_len;
  logic       out_err;

  int vec_count;
  int miss_count;

  lrc8_accumulator #(
    .MAX_LEN (16),
    .CNT_W   (5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_lrc   (out_lrc),
    .out_len   (out_len),
    .out_err   (out_err)
  );

  // 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_count++;
    if (obs !== exp) begin
      miss_count++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Present one byte for exactly one cycle; caller is 1 time unit past a rising edge.
  task automatic send_byte(input logic [7:0] d, input logic l);
    check_vec("in_ready_before_byte", 32'(in_ready), 32'h1);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic check_result(input string tag, input logic [7:0] lrc, input logic [4:0] len,
                              input logic err);
    check_vec({tag, "_valid"}, 32'(out_valid), 32'h1);
    check_vec({tag, "_lrc"},   32'(out_lrc),   32'(lrc));
    check_vec({tag, "_len"},   32'(out_len),   32'(len));
    check_vec({tag, "_err"},   32'(out_err),   32'(err));
    check_vec({tag, "_inrdy"}, 32'(in_ready),  32'h0);
  endtask

  initial begin
    vec_count  = 0;
    miss_count = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    in_last    = 1'b0;
    out_ready  = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check_vec("rst_out_valid", 32'(out_valid), 32'h0);
    check_vec("rst_out_lrc",   32'(out_lrc),   32'h0);
    check_vec("rst_out_len",   32'(out_len),   32'h0);
    check_vec("rst_out_err",   32'(out_err),   32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_vec("post_rst_in_ready", 32'(in_ready), 32'h1);

    // 1: FF,01,00,FF -> 01, len 4
    out_ready = 1'b1;
    send_byte(8'hFF, 1'b0);
    check_vec("t1_no_early_valid", 32'(out_valid), 32'h0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'hFF, 1'b1);
    check_result("t1", 8'h01, 5'd4, 1'b0);
    @(posedge clk);
    #1;
    check_vec("t1_valid_drop", 32'(out_valid), 32'h0);
    check_vec("t1_in_ready_back", 32'(in_ready), 32'h1);
    check_vec("t1_lrc_held", 32'(out_lrc), 32'h01);

    // 2: two single-byte frames
    send_byte(8'h59, 1'b1);
    check_result("t2a", 8'h59, 5'd1, 1'b0);
    @(posedge clk);
    #1;
    send_byte(8'hBE, 1'b1);
    check_result("t2b", 8'hBE, 5'd1, 1'b0);
    @(posedge clk);
    #1;
    check_vec("t2_valid_drop", 32'(out_valid), 32'h0);

    // 3: AA,72 with downstream stalled for 5 cycles -> D8
    out_ready = 1'b0;
    send_byte(8'hAA, 1'b0);
    send_byte(8'h72, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check_result("t3_stall", 8'hD8, 5'd2, 1'b0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    check_vec("t3_still_valid", 32'(out_valid), 32'h1);
    @(posedge clk);
    #1;
    check_vec("t3_valid_drop", 32'(out_valid), 32'h0);
    check_vec("t3_in_ready_back", 32'(in_ready), 32'h1);

    // 4: 20 bytes of 01, LAST on 20th -> overlength, len 16, lrc 00
    for (int i = 1; i <= 20; i++) begin
      send_byte(8'h01, (i == 20) ? 1'b1 : 1'b0);
      if (i < 20) check_vec("t4_no_valid", 32'(out_valid), 32'h0);
    end
    check_result("t4", 8'h00, 5'd16, 1'b1);
    @(posedge clk);
    #1;

    // 5: exactly 16 bytes 00..0F, LAST on 16th -> normal termination
    for (int i = 0; i < 16; i++) begin
      send_byte(8'(i), (i == 15) ? 1'b1 : 1'b0);
    end
    check_result("t5", 8'h00, 5'd16, 1'b0);
    @(posedge clk);
    #1;

    // 6: async reset after 3 bytes, then single byte 5A
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_vec("t6_rst_valid", 32'(out_valid), 32'h0);
    check_vec("t6_rst_len",   32'(out_len),   32'h0);
    check_vec("t6_rst_lrc",   32'(out_lrc),   32'h0);
    check_vec("t6_rst_err",   32'(out_err),   32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_byte(8'h5A, 1'b1);
    check_result("t6", 8'h5A, 5'd1, 1'b0);
    @(posedge clk);
    #1;
    check_vec("t6_valid_drop", 32'(out_valid), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
